// File: rtl/ascon_round_ctrl_if.sv
// Bundle of all non-clock/reset signals of the ASCON round sequencer.
// master: the sequencer itself. slave: the register file / round engine side.
//
// Handshake semantics: load_state_o, round_start_o, update_state_o,
// finished_o and err_o are single-cycle strobes with no back-pressure.
// round_done_i is a level that the sequencer samples only while it is
// waiting for the round it last requested. start_i and abort_i are
// sampled on every rising clock edge.
interface ascon_round_ctrl_if;
  logic       start_i;
  logic [3:0] num_rounds_i;
  logic       abort_i;
  logic       round_done_i;
  logic       intr_clr_i;
  logic       busy_o;
  logic       load_state_o;
  logic       round_start_o;
  logic [3:0] round_idx_o;
  logic [7:0] rc_o;
  logic       update_state_o;
  logic       finished_o;
  logic       intr_o;
  logic       err_o;
  logic [2:0] dbg_state_o;

  modport master (
    input  start_i, num_rounds_i, abort_i, round_done_i, intr_clr_i,
    output busy_o, load_state_o, round_start_o, round_idx_o, rc_o,
           update_state_o, finished_o, intr_o, err_o, dbg_state_o
  );

  modport slave (
    output start_i, num_rounds_i, abort_i, round_done_i, intr_clr_i,
    input  busy_o, load_state_o, round_start_o, round_idx_o, rc_o,
           update_state_o, finished_o, intr_o, err_o, dbg_state_o
  );
endinterface

// File: rtl/ascon_round_ctrl.sv
// Sequencer for the ASCON permutation: loads the state, issues one round
// request per round with its round constant, waits for the engine, then
// writes the state back and raises finished plus a sticky interrupt.
module ascon_round_ctrl #(
  parameter int MAX_ROUNDS = 12,
  parameter int TIMEOUT    = 255
) (
  input logic                clk_i,
  input logic                rst_i,
  ascon_round_ctrl_if.master bus
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    ROUND  = 3'd2,
    WAIT   = 3'd3,
    UPDATE = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          intr_q, intr_d;
  logic          start_ok;
  logic          busy;

  // A start is only accepted for a round count inside 1..MAX_ROUNDS.
  assign start_ok = (bus.num_rounds_i != 4'd0) &&
                    (bus.num_rounds_i <= 4'(MAX_ROUNDS));
  assign busy     = (state_q != IDLE);

  // State, round index, timeout counter and the two registered flags.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      intr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      intr_q  <= intr_d;
    end
  end

  // Next-state logic; abort overrides everything while busy.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    intr_d  = intr_q & ~bus.intr_clr_i;

    case (state_q)
      IDLE: begin
        // Abort together with start drops the start silently.
        if (bus.start_i && !bus.abort_i) begin
          if (start_ok) begin
            idx_d   = 4'(MAX_ROUNDS) - bus.num_rounds_i;
            state_d = LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: state_d = ROUND;
      ROUND: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.round_done_i) begin
          if (idx_q == 4'(MAX_ROUNDS - 1)) begin
            state_d = UPDATE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = ROUND;
          end
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          // Engine never answered: give up without writing the state back.
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      UPDATE: state_d = DONE;
      DONE: begin
        // Set wins over a coincident clear.
        intr_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A second start while running is flagged but otherwise ignored.
    if (busy && bus.start_i) begin
      err_d = 1'b1;
    end

    if (busy && bus.abort_i) begin
      state_d = IDLE;
      err_d   = 1'b0;
      intr_d  = intr_q & ~bus.intr_clr_i;
    end
  end

  assign bus.busy_o         = busy;
  assign bus.load_state_o   = (state_q == LOAD);
  assign bus.round_start_o  = (state_q == ROUND);
  assign bus.update_state_o = (state_q == UPDATE);
  assign bus.finished_o     = (state_q == DONE);
  assign bus.round_idx_o    = busy ? idx_q : 4'd0;
  assign bus.rc_o           = busy ? {4'd15 - idx_q, idx_q} : 8'd0;
  assign bus.err_o          = err_q;
  assign bus.intr_o         = intr_q;
  assign bus.dbg_state_o    = state_q;

endmodule

// File: tb/tb_ascon_round_ctrl.sv
// Directed bench for ascon_round_ctrl. Inputs change 1 ns after the rising
// edge; outputs are sampled on the falling edge. Cycle 0 is the cycle in
// which start_i is presented.
module tb_ascon_round_ctrl;

  logic clk_i;
  logic rst_i;

  ascon_round_ctrl_if bus ();

  ascon_round_ctrl #(
    .MAX_ROUNDS(12),
    .TIMEOUT   (255)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (bus)
  );

  // clock
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  // round constants for idx 0..11
  logic [7:0]  rc_tab [0:11] = '{8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
                                 8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B};
  logic [11:0] exp_q[$];

  int r_n_load, r_load_cyc, r_n_rs, r_first_rs, r_last_rs;
  int r_n_upd, r_upd_cyc, r_n_fin, r_fin_cyc, r_n_err, r_end;
  logic r_intr_end;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] out_vec();
    return {13'd0, bus.busy_o, bus.load_state_o, bus.round_start_o, bus.round_idx_o,
            bus.rc_o, bus.update_state_o, bus.finished_o, bus.intr_o, bus.err_o};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start_i      = 1'b0;
    bus.num_rounds_i = 4'd0;
    bus.abort_i      = 1'b0;
    bus.round_done_i = 1'b0;
    bus.intr_clr_i   = 1'b0;
  endtask

  // Drives one operation with an engine model answering delay cycles late.
  task automatic run_op(input int n, input int delay, input int abort_cyc,
                        input int busy_start_cyc, input int clr_cyc, input int budget);
    int done_cyc;
    logic [11:0] exp_v;
    r_n_load = 0; r_load_cyc = -1; r_n_rs = 0; r_first_rs = -1; r_last_rs = -1;
    r_n_upd = 0; r_upd_cyc = -1; r_n_fin = 0; r_fin_cyc = -1; r_n_err = 0;
    r_end = -1; r_intr_end = 1'b0;
    exp_q.delete();
    if (n >= 1 && n <= 12)
      for (int i = 12 - n; i < 12; i++) exp_q.push_back({4'(i), rc_tab[i]});
    done_cyc = -1;
    for (int cyc = 0; cyc <= budget; cyc++) begin
      tick();
      bus.start_i      = (cyc == 0) || (cyc == busy_start_cyc);
      bus.num_rounds_i = (cyc == 0) ? 4'(n) : 4'hF;
      bus.abort_i      = (cyc == abort_cyc);
      bus.intr_clr_i   = (cyc == clr_cyc);
      bus.round_done_i = (cyc == done_cyc);
      @(negedge clk_i);
      if (cyc >= 1) begin
        if (bus.load_state_o) begin r_n_load++; r_load_cyc = cyc; end
        if (bus.round_start_o) begin
          if (r_n_rs == 0) r_first_rs = cyc;
          r_last_rs = cyc;
          r_n_rs++;
          done_cyc = cyc + 1 + delay;
          chk("round_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            chk("idx_rc", {20'd0, bus.round_idx_o, bus.rc_o}, {20'd0, exp_v});
          end
        end
        if (bus.update_state_o) begin r_n_upd++; r_upd_cyc = cyc; end
        if (bus.finished_o) begin r_n_fin++; r_fin_cyc = cyc; end
        if (bus.err_o) r_n_err++;
        if (!bus.busy_o) begin
          r_end = cyc;
          r_intr_end = bus.intr_o;
          break;
        end
      end
    end
    chk("op_ended", r_end >= 0, 1);
    idle_inputs();
  endtask

  initial begin
    rst_i = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk_i);
    chk("reset_outputs", out_vec(), 0);
    chk("reset_state", bus.dbg_state_o, 0);
    tick();
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("post_reset_outputs", out_vec(), 0);

    // full 12-round permutation
    run_op(12, 0, -1, -1, -1, 100);
    chk("t12_load_cyc", r_load_cyc, 1);
    chk("t12_n_rs", r_n_rs, 12);
    chk("t12_first_rs", r_first_rs, 2);
    chk("t12_last_rs", r_last_rs, 24);
    chk("t12_upd_cyc", r_upd_cyc, 26);
    chk("t12_fin_cyc", r_fin_cyc, 27);
    chk("t12_n_fin", r_n_fin, 1);
    chk("t12_n_err", r_n_err, 0);
    chk("t12_intr", r_intr_end, 1);

    // 6 rounds, interrupt clear coinciding with DONE
    run_op(6, 0, -1, -1, 15, 100);
    chk("t6_n_rs", r_n_rs, 6);
    chk("t6_last_rs", r_last_rs, 12);
    chk("t6_upd_cyc", r_upd_cyc, 14);
    chk("t6_fin_cyc", r_fin_cyc, 15);
    chk("t6_intr_set_wins", r_intr_end, 1);
    tick();
    bus.intr_clr_i = 1'b1;
    @(negedge clk_i);
    tick();
    bus.intr_clr_i = 1'b0;
    @(negedge clk_i);
    chk("intr_cleared", bus.intr_o, 0);

    // abort in WAIT of the third round
    run_op(12, 0, 7, -1, -1, 100);
    chk("abort_n_rs", r_n_rs, 3);
    chk("abort_end", r_end, 8);
    chk("abort_no_upd", r_n_upd, 0);
    chk("abort_no_fin", r_n_fin, 0);
    chk("abort_no_err", r_n_err, 0);
    chk("abort_no_intr", r_intr_end, 0);

    // abort and start together in IDLE
    run_op(5, 0, 0, -1, -1, 10);
    chk("abort_start_end", r_end, 1);
    chk("abort_start_no_load", r_n_load, 0);
    chk("abort_start_no_err", r_n_err, 0);

    // start while busy (cycle 5 is WAIT of round 2)
    run_op(6, 0, -1, 5, -1, 100);
    chk("busy_start_err", r_n_err, 1);
    chk("busy_start_n_rs", r_n_rs, 6);
    chk("busy_start_fin", r_fin_cyc, 15);
    chk("busy_start_n_upd", r_n_upd, 1);

    // illegal round counts
    run_op(0, 0, -1, -1, -1, 10);
    chk("n0_end", r_end, 1);
    chk("n0_err", r_n_err, 1);
    chk("n0_no_load", r_n_load, 0);
    run_op(13, 0, -1, -1, -1, 10);
    chk("n13_end", r_end, 1);
    chk("n13_err", r_n_err, 1);
    chk("n13_no_load", r_n_load, 0);

    // engine never answers: single round, timeout abort
    run_op(1, 1000, -1, -1, -1, 400);
    chk("to_n_rs", r_n_rs, 1);
    chk("to_first_rs", r_first_rs, 2);
    chk("to_end", r_end, 258);
    chk("to_err", r_n_err, 1);
    chk("to_no_upd", r_n_upd, 0);
    chk("to_no_fin", r_n_fin, 0);
    run_op(3, 0, -1, -1, -1, 100);
    chk("after_to_last_rs", r_last_rs, 6);
    chk("after_to_upd", r_upd_cyc, 8);
    chk("after_to_fin", r_fin_cyc, 9);
    chk("after_to_err", r_n_err, 0);

    // delayed done: two extra cycles per round
    run_op(2, 2, -1, -1, -1, 100);
    chk("dly_last_rs", r_last_rs, 6);
    chk("dly_fin", r_fin_cyc, 11);

    // asynchronous reset in the middle of a round
    tick();
    bus.start_i = 1'b1;
    bus.num_rounds_i = 4'd12;
    repeat (3) begin
      tick();
      idle_inputs();
    end
    chk("pre_rst_busy", bus.busy_o, 1);
    chk("pre_rst_state", bus.dbg_state_o, 3);
    #2;
    rst_i = 1'b1;
    #1;
    chk("mid_rst_outputs", out_vec(), 0);
    tick();
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("after_rst_outputs", out_vec(), 0);
    run_op(2, 0, -1, -1, -1, 100);
    chk("after_rst_fin", r_fin_cyc, 7);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
